acq_sequencer: RTL
==================

Name: acq_sequencer

Overview:
Normal-clock-domain controller that sequences one acquisition run of the sampling datapath.
- Reset and relock the clock generators after a clock-select change.
- Pulse the acquisition/FIFO reset, wait for cross-domain settling, then hold acquisition enable.
- Drop enable on FIFO stall, lost clock lock, or stop command.
- Sits between the SPI register block (commands, config) and the synchronizers feeding the fast clock domain.

Parameters:
RST_CYCLES, 16, cycles clkgen_rst and acq_reset are each held high (>=1)
SETTLE_CYCLES, 8, cycles between acq_reset release and acq_enable assertion; covers synchronizer latency (>=1)
LOCK_TIMEOUT, 65535, maximum cycles spent waiting for clklock in WAIT_LOCK
CNT_W, 16, width of the shared internal down-counter; must hold max(RST_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT)

Ports:
clk  in  1  normal clock (48 MHz)
rst  in  1  asynchronous reset, active-low
cmd_start  in  1  single-cycle pulse: begin run
cmd_stop  in  1  single-cycle pulse: abort or end run
cmd_clear  in  1  single-cycle pulse: clear error flags, return to IDLE
clksel_req  in  1  requested clock select, sampled on accepted cmd_start
clklock  in  1  clock-generator lock, already synchronized to clk
stalled  in  1  FIFO-overflow stall, already synchronized to clk
clksel  out  1  registered clock select driven to the clock generators
clkgen_rst  out  1  clock-generator reset
acq_reset  out  1  datapath/FIFO reset (to the fast-domain synchronizer)
acq_enable  out  1  acquisition enable
busy  out  1  high in every state except IDLE and ERROR
state  out  3  current state code
err_overflow  out  1  sticky: run ended by stall
err_lock  out  1  sticky: lock timeout or lock lost during a run

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, clksel=0, clkgen_rst=0, acq_reset=1, acq_enable=0, busy=0, both error flags 0.
- State codes: IDLE=0, CLK_RST=1, WAIT_LOCK=2, FIFO_RST=3, SETTLE=4, RUN=5, STALLED=6, ERROR=7.
- IDLE:
  - acq_reset=1, acq_enable=0.
  - cmd_start latches clksel<=clksel_req, loads counter=RST_CYCLES-1, enters CLK_RST.
- CLK_RST:
  - clkgen_rst=1 for exactly RST_CYCLES cycles.
  - Then load counter=LOCK_TIMEOUT-1 and enter WAIT_LOCK.
- WAIT_LOCK:
  - clkgen_rst=0.
  - clklock=1 -> load counter=RST_CYCLES-1, enter FIFO_RST.
  - Counter reaches 0 with clklock still low -> set err_lock, enter ERROR.
- FIFO_RST:
  - acq_reset=1 for RST_CYCLES cycles.
  - Then acq_reset=0, load counter=SETTLE_CYCLES-1, enter SETTLE.
- SETTLE: after SETTLE_CYCLES cycles, enter RUN. acq_enable=1 registered on that same transition.
- RUN:
  - acq_enable=1.
  - stalled=1 -> STALLED: acq_enable=0, err_overflow=1.
  - clklock=0 -> ERROR: acq_enable=0, acq_reset=1, err_lock=1.
- STALLED: acq_enable=0, acq_reset=0 (FIFO contents stay readable). Leaves only on cmd_stop, cmd_start, or cmd_clear.
- ERROR:
  - acq_enable=0, acq_reset=1.
  - cmd_clear -> IDLE with flags cleared.
  - cmd_start -> CLK_RST; flags cleared and clksel relatched.
- cmd_stop, from any state other than IDLE: next cycle state=IDLE, acq_enable=0, acq_reset=1, clkgen_rst=0. Error flags are kept.
- cmd_start while busy in CLK_RST..RUN is ignored. In STALLED it restarts from CLK_RST.
- Simultaneous events:
  - stop beats start and clear.
  - clear beats start.
  - In RUN, lock loss beats stall; only err_lock is set.
- The async reset deasserting mid-run returns to IDLE with the reset values above.
- The counter never wraps; it only loads on state entry.

Optional Feature:
ACQ_RUN_LIMIT_EN
- Adds input run_limit[31:0] and output run_done.
- On entry to RUN, a 32-bit counter loads run_limit. It decrements each RUN cycle.
- At 0 (with run_limit != 0): next state=IDLE, run_done pulses 1 cycle, no error flag.
- run_limit=0 means unlimited.
- Without the macro: ports absent, RUN is unbounded.

Decomposition:
- Shared package acq_pkg holds:
  - the 3-bit state typedef and its eight codes;
  - default RST_CYCLES, SETTLE_CYCLES and LOCK_TIMEOUT constants.
- No sub-module. The down-counter and FSM stay in one module; the run-limit counter lives inside the ifdef.

Test Plan:
- Reset: rst=0 then release -> state=0, acq_reset=1, acq_enable=0, clkgen_rst=0.
- Nominal run: cmd_start with clksel_req=1, clklock rising 5 cycles after clkgen_rst falls.
  - clkgen_rst high exactly 16 cycles.
  - acq_reset high exactly 16 cycles.
  - acq_enable rises exactly 8 cycles after acq_reset falls.
  - clksel=1, state=5.
- Lock timeout with LOCK_TIMEOUT=100 and clklock held 0 -> ERROR after exactly 100 WAIT_LOCK cycles, err_lock=1, busy=0. Then cmd_clear -> IDLE, err_lock=0.
- Stall in RUN: stalled=1 -> next cycle acq_enable=0, state=6, err_overflow=1. Then cmd_stop -> state=0, acq_reset=1, err_overflow still 1.
- Simultaneous events: in RUN, clklock=0 and stalled=1 in the same cycle -> ERROR, err_lock=1, err_overflow=0. cmd_start and cmd_stop in the same cycle in STALLED -> IDLE.
- ACQ_RUN_LIMIT_EN with run_limit=10 -> acq_enable high exactly 10 cycles, run_done single pulse, state=0, no error flags.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: state codes and default timing.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLK_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FIFO_RST  = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RUN       = 3'd5,
    ST_STALLED   = 3'd6,
    ST_ERROR     = 3'd7
  } acq_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;

endpackage

// File: rtl/acq_sequencer.sv
// Sequences one acquisition run: clock-generator reset/relock, FIFO reset, settle, run.
// Optional bounded run length when ACQ_RUN_LIMIT_EN is defined (adds run_limit/run_done).
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  input  logic        clksel_req,
  input  logic        clklock,
  input  logic        stalled,
`ifdef ACQ_RUN_LIMIT_EN
  input  logic [31:0] run_limit,
  output logic        run_done,
`endif
  output logic        clksel,
  output logic        clkgen_rst,
  output logic        acq_reset,
  output logic        acq_enable,
  output logic        busy,
  output logic [2:0]  state,
  output logic        err_overflow,
  output logic        err_lock
);

  // Commands are single-cycle pulses with no handshake; every output is a flop
  // whose next value is decoded from the next state, so outputs change with state.
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  acq_state_e       cur_q, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clksel_d, err_ovf_d, err_lock_d;
  logic             clkgen_rst_d, acq_reset_d, acq_enable_d, busy_d;

`ifdef ACQ_RUN_LIMIT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        run_done_d;
`endif

  assign state = cur_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q        <= ST_IDLE;
      cnt_q        <= '0;
      clksel       <= 1'b0;
      clkgen_rst   <= 1'b0;
      acq_reset    <= 1'b1;
      acq_enable   <= 1'b0;
      busy         <= 1'b0;
      err_overflow <= 1'b0;
      err_lock     <= 1'b0;
    end else begin
      cur_q        <= nxt;
      cnt_q        <= cnt_d;
      clksel       <= clksel_d;
      clkgen_rst   <= clkgen_rst_d;
      acq_reset    <= acq_reset_d;
      acq_enable   <= acq_enable_d;
      busy         <= busy_d;
      err_overflow <= err_ovf_d;
      err_lock     <= err_lock_d;
    end
  end

`ifdef ACQ_RUN_LIMIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
      run_done  <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      run_done  <= run_done_d;
    end
  end
`endif

  always_comb begin
    nxt        = cur_q;
    cnt_d      = cnt_q;
    clksel_d   = clksel;
    err_ovf_d  = err_overflow;
    err_lock_d = err_lock;
`ifdef ACQ_RUN_LIMIT_EN
    run_cnt_d  = run_cnt_q;
    run_done_d = 1'b0;
`endif
    // Priority: stop, then clear, then per-state events.
    if (cmd_stop) begin
      nxt = ST_IDLE;
    end else if (cmd_clear) begin
      nxt        = ST_IDLE;
      err_ovf_d  = 1'b0;
      err_lock_d = 1'b0;
    end else begin
      case (cur_q)
        ST_IDLE: begin
          if (cmd_start) begin
            nxt      = ST_CLK_RST;
            clksel_d = clksel_req;
            cnt_d    = RST_LOAD;
          end
        end
        ST_CLK_RST: begin
          if (cnt_q == '0) begin
            nxt   = ST_WAIT_LOCK;
            cnt_d = LOCK_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (clklock) begin
            nxt   = ST_FIFO_RST;
            cnt_d = RST_LOAD;
          end else if (cnt_q == '0) begin
            nxt        = ST_ERROR;
            err_lock_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FIFO_RST: begin
          if (cnt_q == '0) begin
            nxt   = ST_SETTLE;
            cnt_d = SETTLE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            nxt = ST_RUN;
`ifdef ACQ_RUN_LIMIT_EN
            run_cnt_d = run_limit;
`endif
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_RUN: begin
          // Lock loss outranks a stall in the same cycle.
          if (!clklock) begin
            nxt        = ST_ERROR;
            err_lock_d = 1'b1;
          end else if (stalled) begin
            nxt       = ST_STALLED;
            err_ovf_d = 1'b1;
          end
`ifdef ACQ_RUN_LIMIT_EN
          // A loaded value of zero never decrements, which makes the run unbounded.
          else if (run_cnt_q == 32'd1) begin
            nxt        = ST_IDLE;
            run_cnt_d  = '0;
            run_done_d = 1'b1;
          end else if (run_cnt_q != '0) begin
            run_cnt_d = run_cnt_q - 32'd1;
          end
`endif
        end
        ST_STALLED: begin
          if (cmd_start) begin
            nxt      = ST_CLK_RST;
            clksel_d = clksel_req;
            cnt_d    = RST_LOAD;
          end
        end
        ST_ERROR: begin
          if (cmd_start) begin
            nxt        = ST_CLK_RST;
            clksel_d   = clksel_req;
            cnt_d      = RST_LOAD;
            err_ovf_d  = 1'b0;
            err_lock_d = 1'b0;
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end

    clkgen_rst_d = (nxt == ST_CLK_RST);
    acq_reset_d  = (nxt == ST_IDLE) || (nxt == ST_FIFO_RST) || (nxt == ST_ERROR);
    acq_enable_d = (nxt == ST_RUN);
    busy_d       = (nxt != ST_IDLE) && (nxt != ST_ERROR);
  end

endmodule
